// File: rtl/request_encoder.sv
// request_encoder: latches 32 request strobes into a pending mask and drains it one index
// at a time over valid/ready, round-robin from a search pointer or fixed lowest-first.
module request_encoder #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] req,
    input  logic        ready,
    output logic        valid,
    output logic [4:0]  index,
    output logic [31:0] pending,
    output logic [5:0]  count
);
    logic [4:0]  ptr;
    logic [4:0]  off;
    logic [31:0] rot;
    logic        pop;

    // Rotate pending so ptr lands at bit 0, then take the lowest set bit of the rotation.
    always_comb begin
        rot = '0;
        off = '0;
        count = '0;
        for (int i = 0; i < 32; i++) begin
            rot[i] = pending[5'(i) + ptr];
            count = count + 6'(pending[i]);
        end
        for (int i = 31; i >= 0; i--)
            if (rot[i]) off = 5'(i);
        valid = |pending;
        index = valid ? off + ptr : 5'd0;
        pop = valid & ready;
    end

    // A new req outranks the clear of the popped bit.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            pending <= '0;
            ptr <= '0;
        end else begin
            pending <= (pending & ~(pop ? 32'd1 << index : 32'd0)) | req;
            if (pop && ROUND_ROBIN) ptr <= index + 5'd1;
        end
endmodule

// File: tb/tb_request_encoder.sv
// tb_request_encoder: directed stimulus with scoreboard queues of expected pop indices
// for a round-robin instance and a fixed-priority instance driven in parallel.
module tb_request_encoder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] req = '0;
    logic        ready = 1'b0;
    logic        valid, valid0;
    logic [4:0]  index, index0;
    logic [31:0] pending, pending0;
    logic [5:0]  count, count0;
    logic [31:0] dec;
    int          errors = 0;
    int          checks = 0;
    int          rr_q[$];
    int          fp_q[$];

    request_encoder #(.ROUND_ROBIN(1'b1)) dut (
        .clock(clock), .reset(reset), .req(req), .ready(ready),
        .valid(valid), .index(index), .pending(pending), .count(count)
    );

    request_encoder #(.ROUND_ROBIN(1'b0)) dut0 (
        .clock(clock), .reset(reset), .req(req), .ready(ready),
        .valid(valid0), .index(index0), .pending(pending0), .count(count0)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic [31:0] r, input logic rd);
        @(posedge clock);
        #1;
        req = r;
        ready = rd;
    endtask

    task automatic push(input int rr, input int fp);
        rr_q.push_back(rr);
        fp_q.push_back(fp);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        req = '0;
        ready = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic queues_empty(input string name);
        check({name, "_rr_left"}, rr_q.size(), 0);
        check({name, "_fp_left"}, fp_q.size(), 0);
    endtask

    // Scoreboard monitors: a pop happens on the next edge whenever valid & ready.
    always @(negedge clock)
        if (!reset && valid && ready) begin
            if (rr_q.size() == 0) check("rr_unexpected_pop", {27'd0, index}, 32'hFFFF_FFFF);
            else check("rr_pop", {27'd0, index}, rr_q.pop_front());
        end

    always @(negedge clock)
        if (!reset && valid0 && ready) begin
            if (fp_q.size() == 0) check("fp_unexpected_pop", {27'd0, index0}, 32'hFFFF_FFFF);
            else check("fp_pop", {27'd0, index0}, fp_q.pop_front());
        end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset without any clock edge
        #1 reset = 1'b1;
        #1;
        check("rst_valid", valid, 0);
        check("rst_index", index, 0);
        check("rst_pending", pending, 0);
        check("rst_count", count, 0);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("idle_valid", valid, 0);
            check("idle_index", index, 0);
            check("idle_pending", pending, 0);
            check("idle_count", count, 0);
        end

        // Decoder round-trip
        for (int k = 0; k < 32; k++) begin
            step(32'd1 << k, 1'b1);
            push(k, k);
            step(32'd0, 1'b1);
            @(negedge clock);
            dec = 32'd1 << index;
            check("rt_valid", valid, 1);
            check("rt_index", index, k);
            check("rt_decode", dec, 32'd1 << k);
            check("rt_count", count, 1);
        end
        step(32'd0, 1'b0);
        @(negedge clock);
        check("rt_drained", valid, 0);
        queues_empty("rt");

        // Round-robin order
        pulse_reset();
        step(32'h8000_0011, 1'b1);
        push(0, 0);
        push(4, 4);
        push(31, 31);
        repeat (3) step(32'd0, 1'b1);
        step(32'd0, 1'b0);
        @(negedge clock);
        check("rr_done_valid", valid, 0);
        check("rr_done_count", count, 0);
        queues_empty("rr");

        // Wrap-around: ptr = 5 after popping 4, then ptr = 1 after popping 0
        pulse_reset();
        step(32'h0000_0010, 1'b1);
        step(32'd0, 1'b1);
        push(4, 4);
        step(32'h8000_0001, 1'b1);
        push(31, 0);
        push(0, 31);
        step(32'd0, 1'b1);
        step(32'd0, 1'b1);
        step(32'h0000_0003, 1'b1);
        push(1, 0);
        push(0, 1);
        repeat (3) step(32'd0, 1'b1);
        step(32'd0, 1'b0);
        @(negedge clock);
        check("wrap_done_valid", valid, 0);
        check("wrap_done_valid0", valid0, 0);
        queues_empty("wrap");

        // Simultaneous set and clear of the same bit
        pulse_reset();
        step(32'h0000_0008, 1'b0);
        step(32'h0000_0008, 1'b1);
        push(3, 3);
        step(32'd0, 1'b1);
        @(negedge clock);
        check("sc_pending", pending, 32'h0000_0008);
        check("sc_valid", valid, 1);
        check("sc_index", index, 3);
        check("sc_count", count, 1);
        push(3, 3);
        step(32'd0, 1'b0);
        @(negedge clock);
        check("sc_drained", valid, 0);
        queues_empty("sc");

        // Full mask, two pops, then reset between edges
        pulse_reset();
        step(32'hFFFF_FFFF, 1'b0);
        step(32'd0, 1'b0);
        @(negedge clock);
        check("full_pending", pending, 32'hFFFF_FFFF);
        check("full_count", count, 32);
        step(32'd0, 1'b1);
        push(0, 0);
        push(1, 1);
        step(32'd0, 1'b1);
        step(32'd0, 1'b0);
        @(negedge clock);
        check("two_pop_count", count, 30);
        check("two_pop_index", index, 2);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_index", index, 0);
        check("mid_rst_pending", pending, 0);
        #1 reset = 1'b0;
        step(32'h0000_0400, 1'b0);
        step(32'd0, 1'b1);
        @(negedge clock);
        check("post_rst_index", index, 10);
        check("post_rst_count", count, 1);
        push(10, 10);
        step(32'd0, 1'b0);
        @(negedge clock);
        check("post_rst_drained", valid, 0);
        queues_empty("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
